// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and constants for the SPI master arbiter
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_t;

  // {CPOL, CPHA}
  typedef logic [1:0] spi_mode_t;

  localparam spi_mode_t MODE0 = 2'b00;
  localparam spi_mode_t MODE1 = 2'b01;
  localparam spi_mode_t MODE2 = 2'b10;
  localparam spi_mode_t MODE3 = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  int             j;
  logic [IDX_W-1:0] jj;

  // Scan farthest-to-nearest so the closest request at/after ptr is the last writer.
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j  = (int'(ptr) + k) % NUM_REQ;
      jj = IDX_W'(j);
      if (req[jj]) begin
        grant     = '0;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin sharing of one SPI master among NUM_REQ requesters
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int START_LEN   = 2,
  parameter int TIMEOUT_CYC = 4096,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]      req_mode,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      m_start,
  output logic [1:0]                m_mode,
  output logic [DATA_W-1:0]         m_data_tx,
  input  logic                      m_done,
  input  logic [DATA_W-1:0]         m_data_rx,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAUNCH_LAST  = CNT_W'(START_LEN - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic               done_q;
  logic               done_edge;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;

  assign done_edge = m_done && !done_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (|req_valid) state_n = LAUNCH;
      LAUNCH:    if (cnt == LAUNCH_LAST) state_n = WAIT_DONE;
      WAIT_DONE: if (done_edge || cnt == TIMEOUT_LAST) state_n = RESP;
      RESP:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    m_start   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    req_ready = arb_grant;
      LAUNCH:  m_start = 1'b1;
      RESP:    rsp_valid[grant_id] = 1'b1;
      default: ;
    endcase
  end

  // One counter times both the start pulse and the done watchdog; it clears between phases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      grant_id  <= '0;
      m_data_tx <= '0;
      m_mode    <= MODE0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      done_q    <= 1'b0;
      cnt       <= '0;
    end else begin
      done_q <= m_done;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id  <= arb_idx;
            m_data_tx <= req_data[int'(arb_idx)*DATA_W +: DATA_W];
            m_mode    <= req_mode[int'(arb_idx)*2 +: 2];
            ptr       <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            cnt       <= '0;
          end
        end
        LAUNCH: begin
          if (cnt == LAUNCH_LAST) cnt <= '0;
          else                    cnt <= cnt + 1'b1;
        end
        WAIT_DONE: begin
          if (done_edge) begin
            rsp_data <= m_data_rx;
            rsp_err  <= 1'b0;
          end else if (cnt == TIMEOUT_LAST) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - directed self-checking bench for spi_master_arbiter
module tb_spi_master_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [7:0]  req_mode;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        m_start;
  logic [1:0]  m_mode;
  logic [7:0]  m_data_tx;
  logic        m_done;
  logic [7:0]  m_data_rx;
  logic        busy;
  logic [1:0]  grant_id;

  int tests = 0;
  int fails = 0;

  spi_master_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .m_start   (m_start),
    .m_mode    (m_mode),
    .m_data_tx (m_data_tx),
    .m_done    (m_done),
    .m_data_rx (m_data_rx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_valid = '0;
    m_done = 1'b0;
    m_data_rx = '0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Enter at the first LAUNCH negedge, leave at the first WAIT_DONE negedge.
  task automatic launch_phase(input logic [1:0] emode, input logic [7:0] etx, input int idx);
    int starts = 0;
    while (m_start === 1'b1 && starts < 16) begin
      chk("launch_mode", m_mode, emode);
      chk("launch_tx", m_data_tx, etx);
      chk("launch_grant", grant_id, idx);
      starts++;
      tick;
    end
    chk("start_len", starts, 2);
    chk("wait_busy", busy, 1);
    chk("wait_mode", m_mode, emode);
  endtask

  // Full transaction with an immediate done pulse; leaves at the IDLE negedge after RESP.
  task automatic serve(input logic [7:0] rx, input logic [1:0] emode, input logic [7:0] etx,
                       input int idx);
    launch_phase(emode, etx, idx);
    m_data_rx = rx;
    m_done = 1'b1;
    tick;
    chk("rsp_valid", rsp_valid, 32'(1) << idx);
    chk("rsp_data", rsp_data, rx);
    chk("rsp_err", rsp_err, 0);
    chk("resp_mode", m_mode, emode);
    m_done = 1'b0;
    tick;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_mode", m_mode, emode);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_data = 32'h13121110;
    req_mode = {2'b11, 2'b10, 2'b01, 2'b00};
    m_done = 1'b0;
    m_data_rx = '0;
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_m_start", m_start, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_m_mode", m_mode, 0);
    chk("rst_m_data_tx", m_data_tx, 0);
    chk("rst_grant_id", grant_id, 0);
    reset = 1'b0;
    tick;

    // single requester 1
    req_data[15:8] = 8'hBD;
    req_mode[3:2] = 2'b10;
    req_valid = 4'b0010;
    #1;
    chk("t1_req_ready", req_ready, 4'b0010);
    tick;
    req_valid = '0;
    chk("t1_req_ready_drop", req_ready, 0);
    serve(8'hE7, 2'b10, 8'hBD, 1);

    // all four held valid after reset
    do_reset;
    req_data = 32'h13121110;
    req_mode = {2'b11, 2'b10, 2'b01, 2'b00};
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_req_ready", req_ready, 32'(1) << (k % 4));
      tick;
      serve(8'h10 + 8'(k % 4), 2'(k % 4), 8'h10 + 8'(k % 4), k % 4);
    end

    // timeout on requester 2, then requester 0 is served
    req_valid = 4'b0101;
    #1;
    chk("to_req_ready", req_ready, 4'b0100);
    tick;
    launch_phase(2'b10, 8'h12, 2);
    for (int i = 0; i < 4095; i++) tick;
    chk("to_not_yet", rsp_valid, 0);
    tick;
    chk("to_rsp_valid", rsp_valid, 4'b0100);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_data", rsp_data, 0);
    tick;
    chk("to_next_ready", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    serve(8'h5A, 2'b00, 8'h10, 0);

    // m_done stuck high from before launch
    m_done = 1'b1;
    req_valid = 4'b1000;
    #1;
    chk("lvl_req_ready", req_ready, 4'b1000);
    tick;
    req_valid = '0;
    launch_phase(2'b11, 8'h13, 3);
    for (int i = 0; i < 5; i++) begin
      chk("lvl_no_rsp", rsp_valid, 0);
      chk("lvl_busy", busy, 1);
      tick;
    end
    m_done = 1'b0;
    tick;
    chk("lvl_no_rsp_low", rsp_valid, 0);
    m_data_rx = 8'hC3;
    m_done = 1'b1;
    tick;
    chk("lvl_rsp_valid", rsp_valid, 4'b1000);
    chk("lvl_rsp_data", rsp_data, 8'hC3);
    m_done = 1'b0;
    tick;

    // reset during WAIT_DONE of requester 2
    req_valid = 4'b0100;
    #1;
    chk("rm_req_ready", req_ready, 4'b0100);
    tick;
    req_valid = 4'b1001;
    launch_phase(2'b10, 8'h12, 2);
    tick;
    tick;
    reset = 1'b1;
    #1;
    chk("rm_m_start", m_start, 0);
    chk("rm_busy", busy, 0);
    chk("rm_rsp_valid", rsp_valid, 0);
    chk("rm_m_data_tx", m_data_tx, 0);
    tick;
    reset = 1'b0;
    #1;
    chk("rm_next_ready", req_ready, 4'b0001);
    chk("rm_rsp_valid2", rsp_valid, 0);
    tick;
    req_valid = '0;
    serve(8'h81, 2'b00, 8'h10, 0);

    // back-to-back mode changes
    do_reset;
    req_data[7:0] = 8'h6D;
    req_mode[1:0] = 2'b00;
    req_data[23:16] = 8'hF0;
    req_mode[5:4] = 2'b11;
    req_valid = 4'b0101;
    #1;
    chk("bb_ready0", req_ready, 4'b0001);
    tick;
    serve(8'h11, 2'b00, 8'h6D, 0);
    chk("bb_ready2", req_ready, 4'b0100);
    tick;
    req_valid = '0;
    serve(8'h22, 2'b11, 8'hF0, 2);
    tick;
    chk("bb_mode_hold", m_mode, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
Shares one SPI master engine among NUM_REQ independent requesters. Each requester supplies a byte and an SPI mode. The block arbitrates round-robin and sequences the master's start/mode/data_tx. It waits for the master's done, then returns data_rx to the granted requester. A watchdog on done keeps a stuck master from hanging the bus.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, SPI frame width
START_LEN, 2, cycles m_start is held high per transaction (>=1)
TIMEOUT_CYC, 4096, max cycles in WAIT_DONE before error completion

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester transaction request, level
req_data  input  NUM_REQ*DATA_W  per-requester tx byte, slice i = requester i
req_mode  input  NUM_REQ*2  per-requester SPI mode {CPOL,CPHA}
req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester
rsp_valid  output  NUM_REQ  one-cycle completion pulse to the owning requester
rsp_data  output  DATA_W  received byte, valid with any rsp_valid bit
rsp_err  output  1  timeout flag, valid with rsp_valid
m_start  output  1  to master start
m_mode  output  2  to master mode
m_data_tx  output  DATA_W  to master data_tx
m_done  input  1  from master done (level or pulse)
m_data_rx  input  DATA_W  from master data_rx
busy  output  1  high in any state except IDLE
grant_id  output  $clog2(NUM_REQ)  index of the current or last owner

Behaviour:
- Reset (async): state=IDLE. Outputs: req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, m_start=0, m_mode=2'b00, m_data_tx=0, busy=0, grant_id=0. RR pointer=0, so requester 0 has top priority. done_q=0, timeout counter=0.
- FSM states:
  - IDLE: if any req_valid, pick the first set bit at or after the pointer, wrapping. Pulse req_ready[w] this cycle. Latch req_data[w] into m_data_tx, req_mode[w] into m_mode, and w into grant_id. Set pointer=(w+1) mod NUM_REQ. Go to LAUNCH.
  - LAUNCH: m_start=1 for exactly START_LEN cycles, then WAIT_DONE. The counter clears on entry.
  - WAIT_DONE: m_start=0. Done is the rising edge m_done && !done_q. On done, capture m_data_rx into rsp_data, rsp_err=0, go to RESP. If the counter reaches TIMEOUT_CYC-1 with no edge, set rsp_data=0, rsp_err=1, go to RESP.
  - RESP: rsp_valid[grant_id]=1 for one cycle, then IDLE.
- Latency: from the req_ready cycle, m_start rises the next cycle. rsp_valid follows the done edge by 1 cycle. Minimum 1 IDLE cycle between transactions.
- m_mode and m_data_tx change only on the IDLE->LAUNCH transition. They are held stable through LAUNCH, WAIT_DONE, RESP and subsequent IDLE.
- done_q samples m_done every cycle in all states. m_done edges outside WAIT_DONE are ignored. A level held high from a prior transaction causes no completion.
- req_valid is sampled only in IDLE. Deasserting it after accept does not abort the transaction. A requester may reassert in the same cycle as its rsp_valid, and it is considered at the next IDLE.
- Reset asserted mid-transaction drops m_start and busy immediately. No rsp_valid is issued for the aborted request.
- Timeout counter width is $clog2(TIMEOUT_CYC). No wrap: it saturates at compare.

Decomposition:
- Package spi_arb_pkg:
  - state enum (IDLE, LAUNCH, WAIT_DONE, RESP)
  - spi_mode_t (2-bit {CPOL,CPHA})
  - mode constants MODE0..MODE3
- Sub-module rr_arbiter, parameterised by NUM_REQ:
  - inputs: req vector, pointer
  - outputs: one-hot grant and binary index
  - combinational; the pointer register stays in the top.

Test Plan:
- Single requester 1 sends data 0xBD, mode 2'b10; master model returns 0xE7 -> req_ready[1] pulses; m_start high 2 cycles; m_data_tx=0xBD, m_mode=2'b10; rsp_valid[1] for 1 cycle; rsp_data=0xE7, rsp_err=0.
- All 4 requesters held valid after reset, each sending 0x10+i -> grant order 0,1,2,3,0,1; each rsp_valid[i] returns its own echoed byte; busy never drops for more than 1 cycle between transactions.
- Master model never raises done -> after 4096 cycles in WAIT_DONE, rsp_valid[grant_id]=1, rsp_err=1, rsp_data=0x00; block returns to IDLE and serves the next requester.
- m_done held high from before the launch -> no completion while high; completion occurs 1 cycle after m_done goes low then high.
- Reset pulsed during WAIT_DONE of requester 2 -> m_start=0, busy=0, no rsp_valid; with requesters 0 and 3 both valid, the next grant after reset is 0.
- Requester 0 (mode 2'b00, 0x6D) and requester 2 (mode 2'b11, 0xF0) back-to-back -> m_mode=00 throughout the first transaction and 11 throughout the second; m_mode changes only at the IDLE->LAUNCH edge.
